// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 16-word block and then streams W0..W(ROUNDS-1).
// A 16-word sliding window holds W(t)..W(t+15); each output handshake appends W(t+16).

module mod_xor32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] y
);
  assign y = a ^ b ^ c;
endmodule

module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD_VALID,
  output logic        LOAD_READY,
  input  logic [0:31] LOAD_WORD,
  output logic        W_VALID,
  input  logic        W_READY,
  output logic [0:31] W_OUT,
  output logic [5:0]  W_IDX,
  output logic        DONE
);
  typedef enum logic [1:0] {IDLE, LOAD, GEN} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t             state, state_nxt;
  logic [15:0][31:0]  win;
  logic [3:0]         lcnt;
  logic [5:0]         t;
  logic               done_q;
  logic               load_hs, w_hs, last;
  logic [31:0]        x0, x1, s0, s1, w_new;

  assign LOAD_READY = !RST && (state != GEN);
  assign W_VALID    = (state == GEN);
  assign W_OUT      = win[0];
  assign W_IDX      = t;
  assign DONE       = done_q;

  assign load_hs = LOAD_VALID & LOAD_READY;
  assign w_hs    = W_VALID & W_READY;
  assign last    = w_hs && (t == LAST_T);

  // win[1] is W(t+1) (the t-15 term for W(t+16)), win[14] is W(t+14) (the t-2 term)
  assign x0 = win[1];
  assign x1 = win[14];

  mod_xor32 u_s0 (
    .a({x0[6:0],  x0[31:7]}),
    .b({x0[17:0], x0[31:18]}),
    .c({3'b0,     x0[31:3]}),
    .y(s0)
  );

  mod_xor32 u_s1 (
    .a({x1[16:0], x1[31:17]}),
    .b({x1[18:0], x1[31:19]}),
    .c({10'b0,    x1[31:10]}),
    .y(s1)
  );

  assign w_new = s1 + win[9] + s0 + win[0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_hs) state_nxt = LOAD;
      LOAD:    if (load_hs && lcnt == 4'd15) state_nxt = GEN;
      GEN:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      win    <= '0;
      lcnt   <= '0;
      t      <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= last;
      // lcnt wraps 15 -> 0 on the 16th word, leaving it ready for the next block
      if (load_hs) begin
        win[lcnt] <= LOAD_WORD;
        lcnt      <= lcnt + 4'd1;
      end
      if (w_hs) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
        t       <= last ? 6'd0 : t + 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized bench for sha256_msg_schedule against a direct recurrence model of W0..W63.
module tb_sha256_msg_schedule;
  localparam int ROUNDS = 64;

  logic        CLK, RST, LOAD_VALID, LOAD_READY, W_VALID, W_READY, DONE;
  logic [0:31] LOAD_WORD, W_OUT;
  logic [5:0]  W_IDX;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got   [64];
  int vectors, miscompares;

  sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
    .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .LOAD_WORD(LOAD_WORD), .W_VALID(W_VALID), .W_READY(W_READY), .W_OUT(W_OUT),
    .W_IDX(W_IDX), .DONE(DONE)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int i = 0; i < 64; i++)
      exp_w[i] = (i < 16) ? msg[i] : sig1(exp_w[i-2]) + exp_w[i-7] + sig0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
  endtask

  task automatic load_msg(input int gap);
    int guard;
    build_model();
    for (int i = 0; i < 16; i++) begin
      LOAD_VALID = 1;
      LOAD_WORD  = msg[i];
      guard = 0;
      while (!LOAD_READY && guard < 50) begin
        @(posedge CLK); #1;
        guard++;
      end
      if (!LOAD_READY) begin
        vectors++; miscompares++;
        $display("FAIL load_ready_timeout word %0d got 0 exp 1", i);
        LOAD_VALID = 0;
        return;
      end
      @(posedge CLK); #1;
      LOAD_VALID = 0;
      vectors++;
      if (W_VALID !== (i == 15)) begin
        miscompares++;
        $display("FAIL w_valid_after_load word %0d got %b exp %b", i, W_VALID, (i == 15));
      end
      if (i < 15) repeat (gap) begin
        @(posedge CLK); #1;
        vectors++;
        if (W_VALID !== 1'b0) begin
          miscompares++;
          $display("FAIL w_valid_in_gap word %0d got %b exp 0", i, W_VALID);
        end
      end
    end
  endtask

  // Consumes words until stop_at; on a full drain, ends sampling the DONE cycle.
  task automatic drain(input bit bp, input bit junk, input int stop_at, output int cyc);
    int idx;
    bit rdy;
    idx = 0; cyc = 0;
    while (idx < stop_at && cyc < 8 * ROUNDS) begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      W_READY = rdy;
      if (junk) begin
        LOAD_VALID = 1;
        LOAD_WORD  = $urandom;
        vectors++;
        if (LOAD_READY !== 1'b0) begin
          miscompares++;
          $display("FAIL load_ready_in_gen idx %0d got %b exp 0", idx, LOAD_READY);
        end
      end
      vectors++;
      if ({W_VALID, W_IDX, W_OUT, DONE} !== {1'b1, 6'(idx), exp_w[idx], 1'b0}) begin
        miscompares++;
        $display("FAIL word idx %0d got v=%b i=%0d w=%h d=%b exp v=1 i=%0d w=%h d=0",
                 idx, W_VALID, W_IDX, W_OUT, DONE, idx, exp_w[idx]);
      end
      got[idx] = W_OUT;
      @(posedge CLK); #1;
      cyc++;
      if (rdy) idx++;
    end
    W_READY = 0;
    LOAD_VALID = 0;
    if (idx < stop_at) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout got idx %0d exp %0d", idx, stop_at);
    end else if (stop_at == ROUNDS) begin
      vectors++;
      if ({DONE, W_VALID, LOAD_READY} !== 3'b101) begin
        miscompares++;
        $display("FAIL done_cycle got done=%b v=%b lr=%b exp done=1 v=0 lr=1", DONE, W_VALID, LOAD_READY);
      end
    end
  endtask

  task automatic check_done_cleared(input string name);
    @(posedge CLK); #1;
    vectors++;
    if ({DONE, W_VALID, LOAD_READY} !== 3'b001) begin
      miscompares++;
      $display("FAIL %s got done=%b v=%b lr=%b exp done=0 v=0 lr=1", name, DONE, W_VALID, LOAD_READY);
    end
  endtask

  task automatic check_abc_words(input string name);
    vectors++;
    if ({got[0], got[16], got[17], got[63]} !== {32'h61626380, 32'h61626380, 32'h000F0000, 32'h12B1EDEB}) begin
      miscompares++;
      $display("FAIL %s got %h %h %h %h exp 61626380 61626380 000f0000 12b1edeb",
               name, got[0], got[16], got[17], got[63]);
    end
  endtask

  task automatic test_reset();
    RST = 1; LOAD_VALID = 0; LOAD_WORD = '0; W_READY = 0;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if ({W_VALID, W_OUT, W_IDX, DONE, LOAD_READY} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b w=%h i=%0d d=%b lr=%b exp all 0", W_VALID, W_OUT, W_IDX, DONE, LOAD_READY);
    end
    RST = 0;
    check_done_cleared("reset_release");
  endtask

  task automatic test_abc();
    int cyc;
    set_abc();
    load_msg(0);
    drain(0, 0, ROUNDS, cyc);
    check_abc_words("abc_words");
    check_done_cleared("abc_done_once");
  endtask

  task automatic test_zero();
    int cyc;
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    load_msg(0);
    drain(0, 0, ROUNDS, cyc);
    // GEN cycles plus the DONE cycle, counting the first GEN cycle as 1
    vectors++;
    if (cyc + 1 !== ROUNDS + 1) begin
      miscompares++;
      $display("FAIL zero_done_latency got %0d exp %0d", cyc + 1, ROUNDS + 1);
    end
    check_done_cleared("zero_done_once");
  endtask

  task automatic test_backpressure();
    int cyc;
    set_abc();
    load_msg(0);
    drain(1, 0, ROUNDS, cyc);
    check_abc_words("bp_words");
    check_done_cleared("bp_done_once");
  endtask

  task automatic test_load_junk();
    int cyc;
    set_abc();
    load_msg(0);
    drain(0, 1, ROUNDS, cyc);
    check_abc_words("junk_words");
    set_rand();
    load_msg(0);
    drain(0, 0, ROUNDS, cyc);
    check_done_cleared("junk_next_done_once");
  endtask

  task automatic test_reset_mid_gen();
    int cyc;
    set_abc();
    load_msg(0);
    drain(0, 0, 20, cyc);
    RST = 1;
    #1;
    vectors++;
    if ({W_VALID, W_OUT, W_IDX, DONE, LOAD_READY} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_gen got v=%b w=%h i=%0d d=%b lr=%b exp all 0", W_VALID, W_OUT, W_IDX, DONE, LOAD_READY);
    end
    repeat (3) begin
      @(posedge CLK); #1;
      vectors++;
      if ({DONE, W_VALID} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_hold got d=%b v=%b exp 0 0", DONE, W_VALID);
      end
    end
    RST = 0;
    check_done_cleared("reset_mid_gen_release");
    set_abc();
    load_msg(0);
    drain(0, 0, ROUNDS, cyc);
    check_abc_words("reset_reload_words");
    check_done_cleared("reset_reload_done_once");
  endtask

  task automatic test_gapped_loads();
    int cyc;
    set_abc();
    load_msg(3);
    drain(0, 0, ROUNDS, cyc);
    check_abc_words("gapped_words");
    check_done_cleared("gapped_done_once");
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int b = 0; b < 4; b++) begin
      set_rand();
      load_msg(0);
      drain(1'(b & 1), 0, ROUNDS, cyc);
    end
    check_done_cleared("b2b_done_once");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_abc();
    test_zero();
    test_backpressure();
    test_load_junk();
    test_reset_mid_gen();
    test_gapped_loads();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
